// File: rtl/ups_axi_pkg.sv
// Shared types and constants for the UPS register-bank AXI4-Lite arbiter.
package ups_axi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    RSP  = 3'd5
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [3:0] STRB_ALL        = 4'hF;

endpackage

// File: rtl/ups_axi_arb_if.sv
// Requester command/response ports plus the AXI4-Lite master channels of ups_axi_arb.
interface ups_axi_arb_if #(
  parameter int NR = 2
);
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_wr;
  logic [32*NR-1:0] req_addr;
  logic [32*NR-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    output m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready
  );

endinterface

// File: rtl/ups_rr_arb.sv
// Combinational round-robin pick: first set req bit after last_grant, with wrap.
// Zero latency; no state, the caller decides when a grant is taken.
module ups_rr_arb #(
  parameter int NR = 2
) (
  input  logic [NR-1:0]                           req,
  input  logic [((NR > 1) ? $clog2(NR) : 1)-1:0]  last_grant,
  output logic [NR-1:0]                           gnt,
  output logic [((NR > 1) ? $clog2(NR) : 1)-1:0]  gnt_idx,
  output logic                                    gnt_any
);
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;

  // One extra bit so last_grant + k never overflows before the wrap subtract.
  logic [IW:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NR; k++) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      if (idx >= (IW+1)'(NR)) begin
        idx = idx - (IW+1)'(NR);
      end
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx[IW-1:0];
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ups_axi_arb.sv
// Round-robin share of one AXI4-Lite master among NR requesters; one transaction in flight, 4 cycles min.
// Requesters hold commands until req_ready; define UPS_AXI_ARB_TIMEOUT_EN for a TO_CYC-cycle watchdog abort.
module ups_axi_arb
  import ups_axi_pkg::*;
#(
  parameter int NR     = 2,
  parameter int TO_CYC = 1024
) (
  input logic           clk,
  input logic           rst,
  ups_axi_arb_if.master bus
);
  localparam int IW = (NR > 1) ? $clog2(NR) : 1;

  if (NR < 2 || NR > 8 || TO_CYC < 2 || TO_CYC > 65536) begin : g_param_check
    $error("ups_axi_arb: NR or TO_CYC out of range");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic [NR-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
`ifdef UPS_AXI_ARB_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
`endif

  logic [NR-1:0] win_oh;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_wr;
  logic          aw_pend;
  logic          w_pend;

  ups_rr_arb #(.NR(NR)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .gnt        (win_oh),
    .gnt_idx    (win_idx),
    .gnt_any    (win_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (win_oh[i]) begin
        sel_addr  = bus.req_addr[32*i +: 32];
        sel_wdata = bus.req_wdata[32*i +: 32];
        sel_wr    = bus.req_wr[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    aw_pend     = 1'b0;
    w_pend      = 1'b0;
`ifdef UPS_AXI_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_any) begin
          last_d  = win_idx;
          id_d    = win_idx;
          addr_d  = sel_addr & 32'hFFFF_FFFC;
          wdata_d = sel_wdata;
`ifdef UPS_AXI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (sel_wr) begin
            state_d   = AWW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = AR;
            arvalid_d = 1'b1;
          end
        end
      end
      AR: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (bus.m_rvalid) begin
          rready_d    = 1'b0;
          rsp_rdata_d = bus.m_rdata;
          rsp_err_d   = (bus.m_rresp != AXI_RESP_OKAY);
          state_d     = RSP;
        end
      end
      AWW: begin
        // AW and W complete independently; B opens once neither is pending.
        aw_pend   = awvalid_q & ~bus.m_awready;
        w_pend    = wvalid_q & ~bus.m_wready;
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          bready_d = 1'b1;
          state_d  = B;
        end
      end
      B: begin
        if (bus.m_bvalid) begin
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = (bus.m_bresp != AXI_RESP_OKAY);
          state_d     = RSP;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase

`ifdef UPS_AXI_ARB_TIMEOUT_EN
    // Abort takes priority over a handshake landing in the same cycle.
    if (state_q inside {AR, R, AWW, B}) begin
      if (cnt_q == 16'(TO_CYC - 1)) begin
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        state_d     = RSP;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif

    if (state_d == RSP) begin
      rsp_valid_d = NR'(1) << id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(NR - 1);
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef UPS_AXI_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef UPS_AXI_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Gate with rst so no command is accepted while reset is asserted.
  assign bus.req_ready = (state_q == IDLE && !rst) ? win_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;
  assign bus.m_awaddr  = addr_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = STRB_ALL;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;

endmodule

// File: tb/tb_ups_axi_arb.sv
// Directed bench for ups_axi_arb (NR=2): read, split write, fairness, error responses, reset, watchdog.
module tb_ups_axi_arb;
  import ups_axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ups_axi_arb_if #(.NR(2)) ifc ();

  ups_axi_arb #(.NR(2), .TO_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Zero-wait slave for one transaction: rvalid/bvalid answer rready/bready immediately,
  // read data is 0xA000_0000 | cycle number of the R cycle.
  task automatic xact(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] resp,
                      input bit drop, output int gid, output int acc,
                      output logic [1:0] rv, output logic [31:0] rd, output logic er);
    bit done;
    done = 1'b0;
    gid = -1; acc = -1; rv = '0; rd = '0; er = 1'b0;
    ifc.req_valid = v;
    ifc.req_wr    = wr;
    for (int c = 0; c < 40 && !done; c++) begin
      ifc.m_rvalid = ifc.m_rready;
      ifc.m_bvalid = ifc.m_bready;
      ifc.m_rresp  = resp;
      ifc.m_bresp  = resp;
      ifc.m_rdata  = 32'hA000_0000 | 32'(cyc);
      #1;
      if (ifc.req_ready != 2'b00 && gid < 0) begin
        gid = ifc.req_ready[1] ? 1 : 0;
        acc = cyc;
      end
      if (ifc.rsp_valid != 2'b00) begin
        rv = ifc.rsp_valid;
        rd = ifc.rsp_rdata;
        er = ifc.rsp_err;
        done = 1'b1;
      end
      tick();
      if (drop && gid >= 0) ifc.req_valid = 2'b00;
    end
    chk("xact_completed", 64'(done), 64'd1);
    ifc.m_rvalid = 1'b0;
    ifc.m_bvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        er;
    int          gid, acc, acc0, n;

    ifc.req_valid = 2'b11;
    ifc.req_wr    = 2'b00;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.m_arready = 1'b0;
    ifc.m_rdata   = '0;
    ifc.m_rresp   = '0;
    ifc.m_rvalid  = 1'b0;
    ifc.m_awready = 1'b0;
    ifc.m_wready  = 1'b0;
    ifc.m_bresp   = '0;
    ifc.m_bvalid  = 1'b0;
    acc0 = 0;

    // Reset state
    tick();
    chk("rst_req_ready", 64'(ifc.req_ready), 64'd0);
    chk("rst_bus_vr", 64'({ifc.m_arvalid, ifc.m_awvalid, ifc.m_wvalid, ifc.m_rready, ifc.m_bready}), 64'd0);
    chk("rst_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), 64'd0);
    chk("rst_addr_data", {ifc.m_araddr, ifc.m_wdata}, 64'd0);
    chk("rst_wstrb", 64'(ifc.m_wstrb), 64'hF);
    rst = 1'b0;
    ifc.req_valid = 2'b00;
    tick();

    // Read by requester 0
    ifc.req_addr[31:0] = 32'h0000_0008;
    ifc.req_valid = 2'b01;
    #1;
    chk("rd_req_ready", 64'(ifc.req_ready), 64'h1);
    tick();
    ifc.req_valid = 2'b00;
    chk("rd_arvalid_c1", 64'(ifc.m_arvalid), 64'd1);
    chk("rd_araddr", 64'(ifc.m_araddr), 64'h8);
    ifc.m_arready = 1'b1;
    tick();
    ifc.m_arready = 1'b0;
    chk("rd_ar_drop_rready", 64'({ifc.m_arvalid, ifc.m_rready}), 64'b01);
    ifc.m_rvalid = 1'b1;
    ifc.m_rdata  = 32'h1234_5678;
    ifc.m_rresp  = AXI_RESP_OKAY;
    tick();
    ifc.m_rvalid = 1'b0;
    chk("rd_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), {29'd0, 2'b01, 1'b0, 32'h1234_5678});
    tick();
    chk("rd_rsp_one_cycle", 64'(ifc.rsp_valid), 64'd0);

    // Write by requester 1, AW accepted two cycles before W
    ifc.req_addr[63:32]  = 32'h0000_0043;
    ifc.req_wdata[63:32] = 32'hCAFE_F00D;
    ifc.req_wr    = 2'b10;
    ifc.req_valid = 2'b10;
    #1;
    chk("wr_req_ready", 64'(ifc.req_ready), 64'h2);
    tick();
    ifc.req_valid = 2'b00;
    chk("wr_aw_w_c1", 64'({ifc.m_awvalid, ifc.m_wvalid}), 64'b11);
    chk("wr_awaddr", 64'(ifc.m_awaddr), 64'h40);
    chk("wr_wdata_strb", 64'({ifc.m_wdata, ifc.m_wstrb}), {28'd0, 32'hCAFE_F00D, 4'hF});
    ifc.m_awready = 1'b1;
    tick();
    ifc.m_awready = 1'b0;
    chk("wr_split_c2", 64'({ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready}), 64'b010);
    tick();
    chk("wr_split_c3", 64'({ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready}), 64'b010);
    ifc.m_wready = 1'b1;
    tick();
    ifc.m_wready = 1'b0;
    chk("wr_bready", 64'({ifc.m_wvalid, ifc.m_bready}), 64'b01);
    ifc.m_bvalid = 1'b1;
    ifc.m_bresp  = AXI_RESP_OKAY;
    tick();
    ifc.m_bvalid = 1'b0;
    chk("wr_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), {29'd0, 2'b10, 1'b0, 32'd0});
    tick();

    // Fairness: both requesters held high, req0 reads, req1 writes, zero-wait slave
    ifc.m_arready = 1'b1;
    ifc.m_awready = 1'b1;
    ifc.m_wready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xact(2'b11, 2'b10, AXI_RESP_OKAY, (i == 5), gid, acc, rv, rd, er);
      if (i == 0) acc0 = acc;
      chk($sformatf("fair_grant%0d", i), 64'(gid), 64'(i % 2));
      chk($sformatf("fair_rsp%0d", i), 64'({rv, er}), (i % 2 == 1) ? 64'b100 : 64'b010);
      chk($sformatf("fair_rdata%0d", i), 64'(rd),
          (i % 2 == 1) ? 64'd0 : 64'(32'hA000_0000 | 32'(acc + 2)));
    end
    chk("fair_throughput", 64'(acc - acc0), 64'd20);

    // Error responses followed by OKAY
    xact(2'b01, 2'b01, AXI_RESP_SLVERR, 1'b1, gid, acc, rv, rd, er);
    chk("bresp_err", 64'({gid[0], rv, er, rd}), {29'd0, 1'b0, 2'b01, 1'b1, 32'd0});
    xact(2'b10, 2'b00, AXI_RESP_OKAY, 1'b1, gid, acc, rv, rd, er);
    chk("okay_after_err", 64'({gid[0], rv, er}), 64'b1100);
    chk("okay_rdata", 64'(rd), 64'(32'hA000_0000 | 32'(acc + 2)));
    xact(2'b01, 2'b00, AXI_RESP_SLVERR, 1'b1, gid, acc, rv, rd, er);
    chk("rresp_err", 64'({gid[0], rv, er}), 64'b0011);
    chk("rresp_err_rdata", 64'(rd), 64'(32'hA000_0000 | 32'(acc + 2)));

    // Reset in R with rvalid low
    ifc.req_wr    = 2'b00;
    ifc.req_valid = 2'b10;
    #1;
    chk("mid_req_ready", 64'(ifc.req_ready), 64'h2);
    tick();
    ifc.req_valid = 2'b00;
    tick();
    chk("mid_in_r", 64'(ifc.m_rready), 64'd1);
    rst = 1'b1;
    ifc.req_valid = 2'b11;
    #1;
    chk("mid_rst_bus", 64'({ifc.m_arvalid, ifc.m_rready, ifc.m_awvalid, ifc.m_wvalid, ifc.m_bready}), 64'd0);
    chk("mid_rst_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata, ifc.req_ready}), 64'd0);
    tick();
    chk("mid_rst_no_rsp", 64'(ifc.rsp_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(ifc.req_ready), 64'h1);
    xact(2'b11, 2'b00, AXI_RESP_OKAY, 1'b1, gid, acc, rv, rd, er);
    chk("post_rst_grant", 64'({gid[0], rv, er}), 64'b0010);

`ifdef UPS_AXI_ARB_TIMEOUT_EN
    // Watchdog: slave never accepts AR
    ifc.m_arready = 1'b0;
    ifc.req_valid = 2'b01;
    #1;
    chk("to_req_ready", 64'(ifc.req_ready), 64'h1);
    tick();
    ifc.req_valid = 2'b00;
    n = 0;
    for (int c = 0; c < 40 && ifc.m_arvalid; c++) begin
      n++;
      tick();
    end
    chk("to_arvalid_cycles", 64'(n), 64'd16);
    chk("to_rsp", 64'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), {29'd0, 2'b01, 1'b1, 32'd0});
    ifc.m_arready = 1'b1;
    tick();
    xact(2'b01, 2'b00, AXI_RESP_OKAY, 1'b1, gid, acc, rv, rd, er);
    chk("to_recover", 64'({gid[0], rv, er}), 64'b0010);
`else
    n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
